// File: rtl/io_reg_pkg.sv
// Shared types and helpers for the I/O register cells.
// Holds the deserializer FSM states and bit-order mapping.
package io_reg_pkg;

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } deser_state_e;

  localparam int unsigned DESER_WIDTH_MIN = 2;
  localparam int unsigned DESER_WIDTH_MAX = 32;

  function automatic bit deser_width_ok(
    input int unsigned w
  );
    return (w >= DESER_WIDTH_MIN) &&
           (w <= DESER_WIDTH_MAX);
  endfunction

  // Position in the output word of serial bit idx.
  function automatic int unsigned bit_pos(
    input int unsigned idx,
    input int unsigned w,
    input bit          msb_first
  );
    return msb_first ? (w - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/in_deser_hold.sv
// One-word output holding register for the deserializer.
// Drops a new word while an unconsumed one waits; flags OVF.
module in_deser_hold #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             dready,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  output logic             ovf
);

  logic take;
  logic drop;

  assign take = load & (~dvalid | dready);
  assign drop = load & dvalid & ~dready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout   <= '0;
      dvalid <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (take) begin
        dout   <= word;
        dvalid <= 1'b1;
      end else if (dvalid && dready) begin
        dvalid <= 1'b0;
      end
      // a drop in the clear cycle keeps the flag set
      ovf <= drop | (ovf & ~ovf_clr);
    end
  end

endmodule

// File: rtl/in_deser_cell.sv
// Serial-to-parallel capture behind the input register cell.
// Framing by ALIGN, bit-slip by SLIP, one-word output hold.
module in_deser_cell
  import io_reg_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             IQC,
  input  logic             QRT,
  input  logic             IQZ,
  input  logic             ALIGN,
  input  logic             SLIP,
  input  logic             DREADY,
  input  logic             OVF_CLR,
  output logic [WIDTH-1:0] DOUT,
  output logic             DVALID,
  output logic             OVF,
  output logic             LOCKED
);

  localparam int unsigned CW =
    ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  if (!deser_width_ok(WIDTH)) begin : g_bad_width
    $error("in_deser_cell: WIDTH out of range");
  end

  deser_state_e     state;
  deser_state_e     state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nxt;
  logic [WIDTH-1:0] mask_0;
  logic [WIDTH-1:0] mask_c;
  logic             done;

  assign mask_0 = ONE << bit_pos(0, WIDTH, MSB_FIRST);
  assign mask_c = ONE << bit_pos(32'(cnt), WIDTH, MSB_FIRST);

  always_ff @(posedge IQC) begin
    if (!QRT) state <= HUNT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      HUNT:  if (ALIGN) state_nxt = SHIFT;
      SHIFT: state_nxt = SHIFT;
      default: state_nxt = HUNT;
    endcase
  end

  always_comb begin
    LOCKED = (state == SHIFT);
  end

  // bits are written straight to their final word position
  always_comb begin
    cnt_nxt  = cnt;
    sreg_nxt = sreg;
    done     = 1'b0;
    if (ALIGN) begin
      cnt_nxt  = CW'(1);
      sreg_nxt = IQZ ? mask_0 : '0;
    end else if (state == SHIFT && !SLIP) begin
      sreg_nxt = (sreg & ~mask_c) | (IQZ ? mask_c : '0);
      if (cnt == LAST) begin
        cnt_nxt = '0;
        done    = 1'b1;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge IQC) begin
    if (!QRT) begin
      cnt  <= '0;
      sreg <= '0;
    end else begin
      cnt  <= cnt_nxt;
      sreg <= sreg_nxt;
    end
  end

  in_deser_hold #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk    (IQC),
    .rst_n  (QRT),
    .load   (done),
    .word   (sreg_nxt),
    .dready (DREADY),
    .ovf_clr(OVF_CLR),
    .dout   (DOUT),
    .dvalid (DVALID),
    .ovf    (OVF)
  );

endmodule

// File: tb/tb_in_deser_cell.sv
// Directed bench for in_deser_cell, LSB-first and MSB-first.
// Both instances share stimulus; expected words are hand-derived.
module tb_in_deser_cell;

  logic       clk = 1'b0;
  logic       qrt = 1'b0;
  logic       iqz = 1'b0;
  logic       align = 1'b0;
  logic       slip = 1'b0;
  logic       dready = 1'b1;
  logic       ovf_clr = 1'b0;
  logic [7:0] dout0, dout1;
  logic       dvalid0, dvalid1;
  logic       ovf0, ovf1;
  logic       locked0, locked1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  in_deser_cell #(.WIDTH(8), .MSB_FIRST(1'b0)) dut0 (
    .IQC(clk), .QRT(qrt), .IQZ(iqz), .ALIGN(align),
    .SLIP(slip), .DREADY(dready), .OVF_CLR(ovf_clr),
    .DOUT(dout0), .DVALID(dvalid0), .OVF(ovf0),
    .LOCKED(locked0)
  );

  in_deser_cell #(.WIDTH(8), .MSB_FIRST(1'b1)) dut1 (
    .IQC(clk), .QRT(qrt), .IQZ(iqz), .ALIGN(align),
    .SLIP(slip), .DREADY(dready), .OVF_CLR(ovf_clr),
    .DOUT(dout1), .DVALID(dvalid1), .OVF(ovf1),
    .LOCKED(locked1)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(
    input logic b, input logic a, input logic s
  );
    iqz = b; align = a; slip = s;
    tick();
    align = 1'b0; slip = 1'b0;
  endtask

  task automatic send_word(
    input logic [7:0] w,
    input bit         a,
    input bit         s0,
    input bit         clr_last,
    input bit         mid_valid,
    input logic [7:0] e0,
    input logic [7:0] e1,
    input bit         e_ovf,
    input string      tag
  );
    for (int i = 0; i < 8; i++) begin
      iqz     = w[i];
      align   = a && (i == 0);
      slip    = s0 && (i == 0);
      ovf_clr = clr_last && (i == 7);
      tick();
      if (i < 7)
        check({tag, "_mid_valid"}, 32'(dvalid0), 32'(mid_valid));
    end
    align = 1'b0; slip = 1'b0; ovf_clr = 1'b0;
    check({tag, "_valid0"}, 32'(dvalid0), 32'd1);
    check({tag, "_valid1"}, 32'(dvalid1), 32'd1);
    check({tag, "_dout0"}, 32'(dout0), 32'(e0));
    check({tag, "_dout1"}, 32'(dout1), 32'(e1));
    check({tag, "_ovf"}, 32'(ovf0), 32'(e_ovf));
  endtask

  logic [8:0] slip_bits;
  logic [8:0] slip_flag;

  initial begin
    // reset and idle
    qrt = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(dvalid0), 32'd0);
    check("rst_locked", 32'(locked0), 32'd0);
    check("rst_dout", 32'(dout0), 32'd0);
    check("rst_ovf", 32'(ovf0), 32'd0);
    qrt = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send_bit(i[0], 1'b0, 1'b0);
      check("idle_valid", 32'(dvalid0 | dvalid1), 32'd0);
      check("idle_locked", 32'(locked0 | locked1), 32'd0);
      check("idle_dout", 32'(dout0 | dout1), 32'd0);
      check("idle_ovf", 32'(ovf0 | ovf1), 32'd0);
    end

    // basic capture and continuous stream
    dready = 1'b1;
    send_word(8'h4D, 1, 0, 0, 0, 8'h4D, 8'hB2, 0, "w1");
    check("locked", 32'(locked0 & locked1), 32'd1);
    send_word(8'h17, 0, 0, 0, 0, 8'h17, 8'hE8, 0, "w2");
    send_bit(1'b0, 1'b0, 1'b0);
    check("valid_one_cycle", 32'(dvalid0), 32'd0);

    // slip on bit 3: 1,0,1,<skip 0>,1,0,0,1,0
    slip_bits = 9'b0_1001_0101;
    slip_flag = 9'b0_0000_1000;
    for (int i = 0; i < 9; i++) begin
      send_bit(slip_bits[i], i == 0, slip_flag[i]);
      if (i < 8)
        check("slip_mid_valid", 32'(dvalid0), 32'd0);
    end
    check("slip_valid", 32'(dvalid0), 32'd1);
    check("slip_dout0", 32'(dout0), 32'h4D);
    check("slip_dout1", 32'(dout1), 32'hB2);

    // realign at count 5 with all-ones junk; ALIGN beats SLIP
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1, i == 0, 1'b0);
      check("junk_valid", 32'(dvalid0), 32'd0);
    end
    send_word(8'h17, 1, 1, 0, 0, 8'h17, 8'hE8, 0, "realign");

    // overflow
    send_word(8'h4D, 0, 0, 0, 0, 8'h4D, 8'hB2, 0, "ov1");
    dready = 1'b0;
    send_word(8'h17, 0, 0, 0, 1, 8'h4D, 8'hB2, 1, "ov2");
    send_word(8'h5A, 0, 0, 1, 1, 8'h4D, 8'hB2, 1, "ov3");
    ovf_clr = 1'b1;
    send_bit(1'b0, 1'b0, 1'b0);
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf0), 32'd0);
    check("ovf_clr_valid", 32'(dvalid0), 32'd1);
    dready = 1'b1;
    send_bit(1'b0, 1'b0, 1'b0);
    check("drain_valid", 32'(dvalid0), 32'd0);

    // reset mid-word with DVALID high
    dready = 1'b0;
    send_word(8'h4D, 1, 0, 0, 0, 8'h4D, 8'hB2, 0, "pre_rst");
    for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0, 1'b0);
    qrt = 1'b0;
    send_bit(1'b1, 1'b1, 1'b0);
    qrt = 1'b1;
    check("mrst_valid", 32'(dvalid0), 32'd0);
    check("mrst_locked", 32'(locked0), 32'd0);
    check("mrst_dout", 32'(dout0), 32'd0);
    for (int i = 0; i < 10; i++) begin
      send_bit(i[1], 1'b0, 1'b0);
      check("post_rst_valid", 32'(dvalid0), 32'd0);
      check("post_rst_locked", 32'(locked0), 32'd0);
    end
    dready = 1'b1;
    send_word(8'h17, 1, 0, 0, 0, 8'h17, 8'hE8, 0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/in_deser_cell.md
# in_deser_cell

Serial-to-parallel capture stage sitting directly downstream of the I/O input register cell. Consumes the registered pad bit on IQZ (one bit per IQC cycle), assembles WIDTH-bit words aligned by a framing strobe, supports bit-slip for word alignment, and presents completed words to the fabric through a valid/ready handshake with a one-word holding register and a sticky overflow flag.

## Interface
- WIDTH, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 0: 0 means first received bit lands in DOUT[0]; 1 means it lands in DOUT[WIDTH-1].
- IQC  input  1  clock; same clock as the upstream input register.
- QRT  input  1  reset; synchronous, active-low.
- IQZ  input  1  serial data bit from the input register cell.
- ALIGN  input  1  word-start strobe; the IQZ bit sampled in the same cycle is bit 0 of a new word.
- SLIP  input  1  bit-slip request; discards the IQZ bit sampled in the same cycle.
- DREADY  input  1  fabric accepts DOUT this cycle.
- OVF_CLR  input  1  clears OVF.
- DOUT  output  WIDTH  assembled word.
- DVALID  output  1  DOUT holds an unconsumed word.
- OVF  output  1  sticky: a completed word was dropped.
- LOCKED  output  1  first ALIGN has been seen since reset.

## Operation
- FSM, two states:
  - HUNT: reset state; IQZ ignored; ALIGN moves to SHIFT and loads bit 0 (count becomes 1).
  - SHIFT: each cycle with SLIP=0 shifts IQZ into the shift register and increments count.
- SHIFT is never left except by reset; LOCKED = (state == SHIFT).
- ALIGN in SHIFT: partial word discarded; sampled bit becomes bit 0; count = 1.
- SLIP in SHIFT (ALIGN=0): bit discarded, count and shift register held.
- ALIGN and SLIP together: ALIGN wins; SLIP ignored.
- Word completion: the cycle in which the bit with index WIDTH-1 is sampled. Count wraps to 0, and the next bit starts a new word without needing ALIGN.
- A word that completes in the same cycle as ALIGN is impossible: ALIGN always yields count = 1.
- Holding register, on completion:
  - Empty, or DVALID and DREADY this cycle: load DOUT and hold DVALID = 1.
  - DVALID and !DREADY: new word dropped, DOUT unchanged, OVF set.
- Without completion: DVALID and DREADY clears DVALID.
- OVF_CLR clears OVF. If a drop occurs in the same cycle, OVF stays 1 (set wins).
- Bit ordering: with MSB_FIRST = 0, bit index i maps to DOUT[i]; otherwise to DOUT[WIDTH-1-i].
- Count width is clog2(WIDTH) bits.

## Timing
- All state updates on posedge IQC.
- Reset (QRT low at an edge): state HUNT, count 0, shift register 0, DOUT 0, DVALID 0, OVF 0, LOCKED 0.
- Reset mid-word or with DVALID high discards everything. Inputs are ignored during reset cycles.
- Latency: the last bit is sampled at edge N; DOUT/DVALID are valid after edge N (registered, no combinational path from IQZ).
- Minimum word spacing is WIDTH cycles. Back-to-back words need no idle cycles when DREADY is high.
- DREADY is only meaningful while DVALID = 1. DOUT is stable while DVALID = 1 and DREADY = 0.
- No combinational paths from inputs to outputs.

## Structure
- Shared package io_reg_pkg holds:
  - the FSM state enum (HUNT, SHIFT);
  - a WIDTH-range check constant;
  - the bit-index mapping function used by MSB_FIRST.
- One natural sub-module, in_deser_hold: the holding register with DVALID/DREADY/OVF logic. It takes a completed word plus a load strobe.
- The top level contains the FSM, counter, and shift register.

## Test plan
- Reset/idle: hold QRT low 3 cycles, drive IQZ toggling with no ALIGN for 20 cycles -> DVALID = 0, LOCKED = 0, DOUT = 0, OVF = 0 throughout.
- Basic capture: WIDTH = 8, MSB_FIRST = 0, DREADY = 1; ALIGN with serial bits 1,0,1,1,0,0,1,0 -> DOUT = 8'h4D, DVALID high for exactly 1 cycle after the 8th edge. Continuous stream gives the next word 8 cycles later.
- MSB_FIRST = 1 with the same stream -> DOUT = 8'hB2.
- Slip/realign: assert SLIP on bit 3 of the 8'h4D stream -> that bit is skipped and the word completes one cycle later. ALIGN mid-word at count 5 -> partial word discarded, no DVALID until 8 bits after the ALIGN.
- Overflow: DREADY = 0 across two completions -> first word retained in DOUT, OVF = 1 after the second completion. OVF_CLR in the same cycle as a third drop -> OVF stays 1. OVF_CLR alone -> OVF = 0.
- Reset mid-operation: QRT low at count 4 with DVALID = 1 -> next cycle DVALID = 0, LOCKED = 0. IQZ is ignored until a new ALIGN.
